// File: rtl/branch_pkg.sv
// Shared types and the branch condition evaluator
// for the execute-stage branch resolve unit.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_e;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t BHT_RST = 2'b01;

  // Operands arrive pre-extended to 64 bits: sign-extended for the
  // signed/equality group, zero-extended for the unsigned group.
  function automatic logic br_eval(
    input logic [63:0] rd1,
    input logic [63:0] rd2,
    input logic [2:0]  funct3
  );
    logic r;
    r = 1'b0;
    case (funct3)
      BEQ:     r = (rd1 == rd2);
      BNE:     r = (rd1 != rd2);
      BLT:     r = ($signed(rd1) <  $signed(rd2));
      BGE:     r = ($signed(rd1) >= $signed(rd2));
      BLTU:    r = (rd1 <  rd2);
      BGEU:    r = (rd1 >= rd2);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Table of 2-bit saturating direction counters with one
// combinational read port and one saturating update port.
module bht_2bit
  import branch_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [IW-1:0] rd_idx,
  output bht_cnt_t      rd_cnt,
  input  logic          upd,
  input  logic [IW-1:0] upd_idx,
  input  logic          upd_taken
);

  bht_cnt_t tbl [DEPTH];
  bht_cnt_t cur;

  assign rd_cnt = tbl[rd_idx];
  assign cur    = tbl[upd_idx];

  // Every entry resets weakly not-taken; updates saturate at 0 and 3.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++)
        tbl[i] <= BHT_RST;
    end else if (upd) begin
      if (upd_taken) begin
        if (cur != 2'b11)
          tbl[upd_idx] <= cur + 2'd1;
      end else begin
        if (cur != 2'b00)
          tbl[upd_idx] <= cur - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: condition compare, target,
// registered outcome, predictor training and perf counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DW        = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [DW-1:0]    lookup_pc_i,
  output logic             pred_taken_o,
  input  logic             valid_i,
  input  logic [DW-1:0]    pc_i,
  input  logic [DW-1:0]    imm_i,
  input  logic [DW-1:0]    rd1_i,
  input  logic [DW-1:0]    rd2_i,
  input  logic [2:0]       funct3_i,
  input  logic             pred_taken_i,
  input  logic             flush_i,
  output logic             res_valid_o,
  output logic             taken_o,
  output logic             mispredict_o,
  output logic [DW-1:0]    target_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [63:0]    a_x;
  logic [63:0]    b_x;
  logic           accept;
  logic           legal;
  logic           taken;
  logic           mis;
  logic           upd;
  logic [DW-1:0]  target;
  bht_cnt_t       lk_cnt;

  assign accept = valid_i && !flush_i;
  assign legal  = (funct3_i[2:1] != 2'b01);
  assign taken  = legal && br_eval(a_x, b_x, funct3_i);
  assign mis    = taken ^ pred_taken_i;
  assign upd    = accept && legal;
  assign target = taken ? (pc_i + imm_i) : (pc_i + DW'(4));

  assign pred_taken_o = lk_cnt[1];

  // Sign-extend for the signed group, zero-extend for the unsigned one.
  always_comb begin
    a_x = {{(64-DW){1'b0}}, rd1_i};
    b_x = {{(64-DW){1'b0}}, rd2_i};
    if (!funct3_i[1]) begin
      a_x = {{(64-DW){rd1_i[DW-1]}}, rd1_i};
      b_x = {{(64-DW){rd2_i[DW-1]}}, rd2_i};
    end
  end

  bht_2bit #(
    .DEPTH (BHT_DEPTH)
  ) u_bht (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .rd_idx    (lookup_pc_i[IDX_W+1:2]),
    .rd_cnt    (lk_cnt),
    .upd       (upd),
    .upd_idx   (pc_i[IDX_W+1:2]),
    .upd_taken (taken)
  );

  // Result registers load on accept; valid drops otherwise, rest hold.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      res_valid_o  <= 1'b0;
      taken_o      <= 1'b0;
      mispredict_o <= 1'b0;
      target_o     <= '0;
      illegal_o    <= 1'b0;
    end else begin
      res_valid_o <= accept;
      if (accept) begin
        taken_o      <= taken;
        mispredict_o <= mis;
        target_o     <= target;
        illegal_o    <= !legal;
      end
    end
  end

  // Perf counters count legal resolutions and stick at all-ones.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (upd) begin
      if (branch_cnt_o != '1)
        branch_cnt_o <= branch_cnt_o + 1'b1;
      if (mis && mispred_cnt_o != '1)
        mispred_cnt_o <= mispred_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised and directed bench for branch_resolve_unit with
// a behavioural model and a per-cycle compare process.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lookup_pc;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [2:0]  funct3;
  logic        pred_in;
  logic        flush;

  logic        pred_out;
  logic        res_valid;
  logic        taken;
  logic        mispredict;
  logic [31:0] target;
  logic        illegal;
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  logic        p4_pred;
  logic        r4_valid;
  logic        r4_taken;
  logic        r4_mis;
  logic [31:0] r4_target;
  logic        r4_illegal;
  logic [3:0]  b4_br;
  logic [3:0]  b4_mis;

  int tests = 0;
  int fails = 0;
  bit run   = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .lookup_pc_i   (lookup_pc),
    .pred_taken_o  (pred_out),
    .valid_i       (valid),
    .pc_i          (pc),
    .imm_i         (imm),
    .rd1_i         (rd1),
    .rd2_i         (rd2),
    .funct3_i      (funct3),
    .pred_taken_i  (pred_in),
    .flush_i       (flush),
    .res_valid_o   (res_valid),
    .taken_o       (taken),
    .mispredict_o  (mispredict),
    .target_o      (target),
    .illegal_o     (illegal),
    .branch_cnt_o  (br_cnt),
    .mispred_cnt_o (mis_cnt)
  );

  branch_resolve_unit #(.CNT_W(4)) dut4 (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .lookup_pc_i   (lookup_pc),
    .pred_taken_o  (p4_pred),
    .valid_i       (valid),
    .pc_i          (pc),
    .imm_i         (imm),
    .rd1_i         (rd1),
    .rd2_i         (rd2),
    .funct3_i      (funct3),
    .pred_taken_i  (pred_in),
    .flush_i       (flush),
    .res_valid_o   (r4_valid),
    .taken_o       (r4_taken),
    .mispredict_o  (r4_mis),
    .target_o      (r4_target),
    .illegal_o     (r4_illegal),
    .branch_cnt_o  (b4_br),
    .mispred_cnt_o (b4_mis)
  );

  // ---------------- behavioural model ----------------
  int          m_bht [64];
  longint      m_br;
  longint      m_mis;
  bit          m_rv;
  bit          m_tk;
  bit          m_mp;
  bit          m_il;
  logic [31:0] m_tg;

  function automatic bit ref_taken(logic [31:0] a, logic [31:0] b,
                                   logic [2:0] f);
    int sa = a;
    int sb = b;
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(logic [31:0] p);
    return int'((p >> 2) % 64);
  endfunction

  function automatic logic [63:0] sat(longint v, int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit lg, tk;
    int ix;
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) m_bht[i] <= 1;
      m_br <= 0; m_mis <= 0;
      m_rv <= 0; m_tk <= 0; m_mp <= 0; m_il <= 0;
      m_tg <= '0;
    end else if (valid && !flush) begin
      lg = !(funct3 == 3'd2 || funct3 == 3'd3);
      tk = lg && ref_taken(rd1, rd2, funct3);
      ix = idx_of(pc);
      m_rv <= 1;
      m_tk <= tk;
      m_mp <= (tk != pred_in);
      m_il <= !lg;
      m_tg <= tk ? pc + imm : pc + 32'd4;
      if (lg) begin
        m_br <= m_br + 1;
        if (tk != pred_in) m_mis <= m_mis + 1;
        if (tk) m_bht[ix] <= (m_bht[ix] < 3) ? m_bht[ix] + 1 : 3;
        else    m_bht[ix] <= (m_bht[ix] > 0) ? m_bht[ix] - 1 : 0;
      end
    end else begin
      m_rv <= 0;
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run && rst_n) begin
      chk("res_valid", 64'(res_valid), 64'(m_rv));
      chk("taken", 64'(taken), 64'(m_tk));
      chk("mispredict", 64'(mispredict), 64'(m_mp));
      chk("target", 64'(target), 64'(m_tg));
      chk("illegal", 64'(illegal), 64'(m_il));
      chk("branch_cnt", 64'(br_cnt), sat(m_br, 32));
      chk("mispred_cnt", 64'(mis_cnt), sat(m_mis, 32));
      chk("branch_cnt4", 64'(b4_br), sat(m_br, 4));
      chk("mispred_cnt4", 64'(b4_mis), sat(m_mis, 4));
      chk("pred_taken", 64'(pred_out),
          64'(m_bht[idx_of(lookup_pc)] >= 2));
      chk("res_valid4", 64'(r4_valid), 64'(m_rv));
      chk("target4", 64'(r4_target), 64'(m_tg));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic br(logic [31:0] p, logic [31:0] im, logic [31:0] a,
                    logic [31:0] b, logic [2:0] f, logic pr);
    valid = 1; flush = 0;
    pc = p; imm = im; rd1 = a; rd2 = b; funct3 = f; pred_in = pr;
    @(negedge clk);
  endtask

  task automatic idle();
    valid = 0; flush = 0;
    @(negedge clk);
  endtask

  task automatic rand_cycles(int n);
    for (int k = 0; k < n; k++) begin
      #1;
      valid   = ($urandom_range(0, 9) < 8);
      flush   = ($urandom_range(0, 9) == 0);
      pc      = ($urandom_range(0, 3) == 0) ? ($urandom & ~32'h3)
                : 32'($urandom_range(0, 511)) << 2;
      imm     = ($urandom_range(0, 1) == 1) ? $urandom
                : 32'($signed(12'($urandom)) & ~1);
      funct3  = 3'($urandom);
      pred_in = 1'($urandom);
      case ($urandom_range(0, 3))
        0: begin rd1 = $urandom; rd2 = rd1; end
        1: begin rd1 = 32'h8000_0000; rd2 = 32'h7FFF_FFFF; end
        2: begin rd1 = $urandom_range(0, 3); rd2 = $urandom_range(0, 3); end
        default: begin rd1 = $urandom; rd2 = $urandom; end
      endcase
      lookup_pc = ($urandom_range(0, 1) == 1) ? pc : $urandom;
      @(negedge clk);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n = 0; valid = 0; flush = 0; pc = '0; imm = '0;
    rd1 = '0; rd2 = '0; funct3 = '0; pred_in = 0; lookup_pc = 32'h100;
    #23;
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_target", 64'(target), 64'd0);
    chk("rst_pred", 64'(pred_out), 64'd0);
    rst_n = 1;
    run = 1;
    @(negedge clk); #1;

    // training: 01 -> 10 -> 11 -> 11
    br(32'h100, 32'h20, 32'd5, 32'd5, 3'b000, 1'b0);
    chk("train1_taken", 64'(taken), 64'd1);
    chk("train1_mis", 64'(mispredict), 64'd1);
    chk("train1_pred", 64'(pred_out), 64'd1);
    #1;
    br(32'h100, 32'h20, 32'd5, 32'd5, 3'b000, 1'b0);
    chk("train2_mis", 64'(mispredict), 64'd1);
    #1;
    br(32'h100, 32'h20, 32'd5, 32'd5, 3'b000, 1'b0);
    chk("train3_mis", 64'(mispredict), 64'd1);
    chk("train_target", 64'(target), 64'h120);
    chk("train_brcnt", 64'(br_cnt), 64'd3);
    chk("train_miscnt", 64'(mis_cnt), 64'd3);
    #1;

    // illegal funct3
    br(32'h100, 32'h20, 32'd5, 32'd5, 3'b010, 1'b0);
    chk("ill_flag", 64'(illegal), 64'd1);
    chk("ill_taken", 64'(taken), 64'd0);
    chk("ill_brcnt", 64'(br_cnt), 64'd3);
    #1;

    // flush drops a not-taken BEQ that would have trained down
    flush = 1;
    valid = 1; funct3 = 3'b000; rd1 = 32'd1; rd2 = 32'd2;
    @(negedge clk);
    chk("flush_valid", 64'(res_valid), 64'd0);
    chk("flush_pred", 64'(pred_out), 64'd1);
    chk("flush_brcnt", 64'(br_cnt), 64'd3);
    #1;

    // signed vs unsigned compares
    br(32'h200, 32'h10, 32'hFFFF_FFFF, 32'h1, 3'b100, 1'b0);
    chk("blt_taken", 64'(taken), 64'd1);
    chk("blt_target", 64'(target), 64'h210);
    #1;
    br(32'h200, 32'h10, 32'hFFFF_FFFF, 32'h1, 3'b110, 1'b0);
    chk("bltu_taken", 64'(taken), 64'd0);
    chk("bltu_target", 64'(target), 64'h204);
    #1;
    br(32'h200, 32'h10, 32'hFFFF_FFFF, 32'h1, 3'b111, 1'b0);
    chk("bgeu_taken", 64'(taken), 64'd1);
    #1;

    // target wrap-around
    br(32'hFFFF_FFFC, 32'h8, 32'd5, 32'd5, 3'b000, 1'b1);
    chk("wrap_taken", 64'(taken), 64'd1);
    chk("wrap_target", 64'(target), 64'h4);
    #1;
    br(32'hFFFF_FFFC, 32'h8, 32'd5, 32'd5, 3'b001, 1'b1);
    chk("wrap_nt_target", 64'(target), 64'h0);
    #1;

    // same-cycle lookup and update, no bypass
    lookup_pc = 32'h40;
    valid = 1; flush = 0; pc = 32'h40; imm = 32'h8;
    rd1 = 32'd7; rd2 = 32'd7; funct3 = 3'b000; pred_in = 0;
    #1;
    chk("same_old_pred", 64'(pred_out), 64'd0);
    @(negedge clk);
    chk("same_new_pred", 64'(pred_out), 64'd1);
    idle();

    rand_cycles(1000);

    // asynchronous reset between edges
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("arst_valid", 64'(res_valid), 64'd0);
    chk("arst_taken", 64'(taken), 64'd0);
    chk("arst_mis", 64'(mispredict), 64'd0);
    chk("arst_target", 64'(target), 64'd0);
    chk("arst_illegal", 64'(illegal), 64'd0);
    chk("arst_brcnt", 64'(br_cnt), 64'd0);
    chk("arst_miscnt", 64'(mis_cnt), 64'd0);
    for (int i = 0; i < 64; i++) begin
      lookup_pc = 32'(i) << 2;
      #0.1;
      chk("arst_bht", 64'(pred_out), 64'd0);
    end
    valid = 0;
    @(negedge clk); #1;
    rst_n = 1;
    @(negedge clk);

    // one taken update lifts a reset entry (01) straight to predict-taken
    #1;
    lookup_pc = 32'h84;
    br(32'h84, 32'h4, 32'd1, 32'd1, 3'b000, 1'b0);
    chk("arst_retrain", 64'(pred_out), 64'd1);

    rand_cycles(1000);
    idle();
    chk("sat4_brcnt", 64'(b4_br), 64'hF);

    run = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
